// File: rtl/system_pkg.sv
// Shared SoC types and helpers for the AHB-Lite fetch/LSU arbiter.
// Owner encoding, HTRANS/HSIZE codes, and byte-enable decoding.
package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [2:0] be_to_hsize(input logic [3:0] be);
        logic [2:0] size;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = HSIZE_BYTE;
            4'b0011, 4'b1100:                   size = HSIZE_HALF;
            default:                            size = HSIZE_WORD;
        endcase
        return size;
    endfunction

    // Lowest enabled byte lane; an empty mask maps to lane 0.
    function automatic logic [1:0] be_to_offset(input logic [3:0] be);
        logic [1:0] off;
        if (be[0])      off = 2'd0;
        else if (be[1]) off = 2'd1;
        else if (be[2]) off = 2'd2;
        else if (be[3]) off = 2'd3;
        else            off = 2'd0;
        return off;
    endfunction

endpackage

// File: rtl/core_ahbl_arbiter.sv
// Shares one AHB-Lite master port between Ibex fetch and LSU interfaces.
// Data has fixed priority; a starvation counter forces periodic fetch grants.
module core_ahbl_arbiter
    import system_pkg::*;
#(
    parameter int ADDR_WIDTH   = system_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = system_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,

    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic                  instr_err_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,

    output logic [ADDR_WIDTH-1:0] ahbl_haddr_o,
    output logic [1:0]            ahbl_htrans_o,
    output logic [2:0]            ahbl_hsize_o,
    output logic [2:0]            ahbl_hburst_o,
    output logic [3:0]            ahbl_hprot_o,
    output logic                  ahbl_hmastlock_o,
    output logic                  ahbl_hwrite_o,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata_o,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata_i,
    input  logic                  ahbl_hready_i,
    input  logic                  ahbl_hresp_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    owner_e                dp_owner;
    logic                  dp_we;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic pick_instr;
    logic done;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign ahbl_hburst_o    = 3'b000;
    assign ahbl_hprot_o     = 4'b0011;
    assign ahbl_hmastlock_o = 1'b0;

    // Grants are held off while reset is asserted so every output shows its reset value.
    assign pick_instr  = instr_req_i && (!data_req_i || starve_cnt == LIMIT);
    assign instr_gnt_o = ahbl_hready_i && !sys_rst_i && pick_instr;
    assign data_gnt_o  = ahbl_hready_i && !sys_rst_i && data_req_i && !pick_instr;

    always_comb begin
        ahbl_htrans_o = HTRANS_IDLE;
        ahbl_haddr_o  = '0;
        ahbl_hwrite_o = 1'b0;
        ahbl_hsize_o  = HSIZE_WORD;
        if (instr_gnt_o) begin
            ahbl_htrans_o = HTRANS_NONSEQ;
            ahbl_haddr_o  = instr_addr_i;
        end else if (data_gnt_o) begin
            ahbl_htrans_o = HTRANS_NONSEQ;
            ahbl_haddr_o  = {data_addr_i[ADDR_WIDTH-1:2], be_to_offset(data_be_i)};
            ahbl_hwrite_o = data_we_i;
            ahbl_hsize_o  = be_to_hsize(data_be_i);
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            starve_cnt <= '0;
        end else if (!instr_req_i || instr_gnt_o) begin
            starve_cnt <= '0;
        end else if (data_gnt_o && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Data-phase tracking: a stalled bus (hready low) freezes the outstanding transfer.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            dp_owner <= OWN_NONE;
            dp_we    <= 1'b0;
            wdata_q  <= '0;
        end else if (ahbl_hready_i) begin
            if (instr_gnt_o) begin
                dp_owner <= OWN_INSTR;
                dp_we    <= 1'b0;
            end else if (data_gnt_o) begin
                dp_owner <= OWN_DATA;
                dp_we    <= data_we_i;
                if (data_we_i) wdata_q <= data_wdata_i;
            end else begin
                dp_owner <= OWN_NONE;
                dp_we    <= 1'b0;
            end
        end
    end

    assign done = ahbl_hready_i && dp_owner != OWN_NONE;

    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = '0;
        if (done && dp_owner == OWN_INSTR) begin
            instr_rvalid_o = 1'b1;
            instr_err_o    = ahbl_hresp_i;
            instr_rdata_o  = dp_we ? '0 : ahbl_hrdata_i;
        end
        if (done && dp_owner == OWN_DATA) begin
            data_rvalid_o = 1'b1;
            data_err_o    = ahbl_hresp_i;
            data_rdata_o  = dp_we ? '0 : ahbl_hrdata_i;
        end
    end

    assign ahbl_hwdata_o = (dp_owner == OWN_DATA && dp_we) ? wdata_q : '0;

endmodule
